// File: rtl/babelfish_pkg.sv
// Shared types and constants for the execute/writeback slice of the core.
package babelfish_pkg;

   localparam int DATA_W = 64;
   localparam int REG_W  = 4;

   localparam logic [REG_W-1:0] REG_RAX = 4'd0;
   localparam logic [REG_W-1:0] REG_RDX = 4'd2;

   typedef enum logic [1:0] {
      IDLE          = 2'd0,
      WRITE_MAIN    = 2'd1,
      WRITE_SPECIAL = 2'd2,
      HALTED        = 2'd3
   } wb_state_t;

endpackage

// File: rtl/wb_retire_counter.sv
// Enable-driven counter that wraps modulo 2^W; also used for perf counters.
module wb_retire_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   output logic [W-1:0] count
);

   // Increment on enable, hold otherwise
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (en) begin
         count <= count + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/execute_writeback.sv
// Writeback stage: captures one completed instruction from Execute and retires it through the
// single register-file write port, splitting two-destination ops across two cycles.
module execute_writeback #(
   parameter int DATA_W       = babelfish_pkg::DATA_W,
   parameter int REG_W        = babelfish_pkg::REG_W,
   parameter int RETIRE_CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    exValidIn,
   output logic                    wbReadyOut,
   input  logic [DATA_W-1:0]       aluResultIn,
   input  logic [DATA_W-1:0]       aluResultSpecialIn,
   input  logic [REG_W-1:0]        destRegIn,
   input  logic                    destRegValidIn,
   input  logic [REG_W-1:0]        destRegSpecialIn,
   input  logic                    destRegSpecialValidIn,
   input  logic [63:0]             currentRipIn,
   input  logic                    killIn,
   output logic                    rfWriteEnOut,
   output logic [REG_W-1:0]        rfWriteRegOut,
   output logic [DATA_W-1:0]       rfWriteDataOut,
   output logic                    sbClearValidOut,
   output logic [REG_W-1:0]        sbClearRegOut,
   output logic                    retireValidOut,
   output logic [63:0]             retireRipOut,
   output logic [RETIRE_CNT_W-1:0] retireCountOut,
   output logic                    haltedOut
);
   import babelfish_pkg::*;

   wb_state_t           state_r;
   wb_state_t           nextState_s;
   logic [REG_W-1:0]    capSpecialReg_r;
   logic [DATA_W-1:0]   capSpecialData_r;
   logic                capSpecialValid_r;
   logic                capKill_r;
   logic [63:0]         capRip_r;

   logic                accept_s;
   logic                nextWrEn_s;
   logic [REG_W-1:0]    nextWrReg_s;
   logic [DATA_W-1:0]   nextWrData_s;
   logic                nextRetire_s;
   logic [63:0]         nextRip_s;

   // Ready whenever the current cycle is the instruction's last and no halt is pending
   always_comb begin
      case (state_r)
         IDLE:          wbReadyOut = 1'b1;
         WRITE_MAIN:    wbReadyOut = !capSpecialValid_r && !capKill_r;
         WRITE_SPECIAL: wbReadyOut = !capKill_r;
         HALTED:        wbReadyOut = 1'b0;
         default:       wbReadyOut = 1'b0;
      endcase
   end

   assign accept_s = exValidIn && wbReadyOut;

   // Next state plus the write/retire values the following cycle will present
   always_comb begin
      nextState_s  = state_r;
      nextWrEn_s   = 1'b0;
      nextWrReg_s  = '0;
      nextWrData_s = '0;
      nextRetire_s = 1'b0;
      nextRip_s    = 64'd0;
      if (accept_s) begin
         // A killed instruction retires in its first cycle and never writes
         nextState_s  = WRITE_MAIN;
         nextWrEn_s   = destRegValidIn && !killIn;
         nextWrReg_s  = destRegIn;
         nextWrData_s = aluResultIn;
         nextRetire_s = !destRegSpecialValidIn || killIn;
         nextRip_s    = currentRipIn;
      end else begin
         case (state_r)
            IDLE:          nextState_s = IDLE;
            WRITE_MAIN: begin
               if (capKill_r) begin
                  nextState_s = HALTED;
               end else if (capSpecialValid_r) begin
                  nextState_s  = WRITE_SPECIAL;
                  nextWrEn_s   = 1'b1;
                  nextWrReg_s  = capSpecialReg_r;
                  nextWrData_s = capSpecialData_r;
                  nextRetire_s = 1'b1;
                  nextRip_s    = capRip_r;
               end else begin
                  nextState_s = IDLE;
               end
            end
            WRITE_SPECIAL: nextState_s = IDLE;
            HALTED:        nextState_s = HALTED;
            default:       nextState_s = IDLE;
         endcase
      end
   end

   // Holding registers for the fields needed after the first writeback cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         capSpecialReg_r   <= '0;
         capSpecialData_r  <= '0;
         capSpecialValid_r <= 1'b0;
         capKill_r         <= 1'b0;
         capRip_r          <= 64'd0;
      end else if (accept_s) begin
         capSpecialReg_r   <= destRegSpecialIn;
         capSpecialData_r  <= aluResultSpecialIn;
         capSpecialValid_r <= destRegSpecialValidIn;
         capKill_r         <= killIn;
         capRip_r          <= currentRipIn;
      end else begin
         capSpecialReg_r   <= capSpecialReg_r;
         capSpecialData_r  <= capSpecialData_r;
         capSpecialValid_r <= capSpecialValid_r;
         capKill_r         <= capKill_r;
         capRip_r          <= capRip_r;
      end
   end

   // State and registered write/clear/retire outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r         <= IDLE;
         rfWriteEnOut    <= 1'b0;
         rfWriteRegOut   <= '0;
         rfWriteDataOut  <= '0;
         sbClearValidOut <= 1'b0;
         sbClearRegOut   <= '0;
         retireValidOut  <= 1'b0;
         retireRipOut    <= 64'd0;
         haltedOut       <= 1'b0;
      end else begin
         state_r         <= nextState_s;
         rfWriteEnOut    <= nextWrEn_s;
         rfWriteRegOut   <= nextWrReg_s;
         rfWriteDataOut  <= nextWrData_s;
         sbClearValidOut <= nextWrEn_s;
         sbClearRegOut   <= nextWrReg_s;
         retireValidOut  <= nextRetire_s;
         retireRipOut    <= nextRip_s;
         haltedOut       <= (nextState_s == HALTED);
      end
   end

   wb_retire_counter #(
      .W (RETIRE_CNT_W)
   ) uRetireCounter (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (nextRetire_s),
      .count   (retireCountOut)
   );

endmodule

// File: tb/tb_execute_writeback.sv
// Bench for execute_writeback: directed steps plus random traffic against a queue-of-cycles model.
module tb_execute_writeback;
   import babelfish_pkg::*;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             exValidIn;
   logic             wbReadyOut;
   logic [63:0]      aluResultIn;
   logic [63:0]      aluResultSpecialIn;
   logic [3:0]       destRegIn;
   logic             destRegValidIn;
   logic [3:0]       destRegSpecialIn;
   logic             destRegSpecialValidIn;
   logic [63:0]      currentRipIn;
   logic             killIn;
   logic             rfWriteEnOut;
   logic [3:0]       rfWriteRegOut;
   logic [63:0]      rfWriteDataOut;
   logic             sbClearValidOut;
   logic [3:0]       sbClearRegOut;
   logic             retireValidOut;
   logic [63:0]      retireRipOut;
   logic [CNT_W-1:0] retireCountOut;
   logic             haltedOut;

   always #5 clk = ~clk;

   execute_writeback #(
      .DATA_W       (64),
      .REG_W        (4),
      .RETIRE_CNT_W (CNT_W)
   ) dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .exValidIn             (exValidIn),
      .wbReadyOut            (wbReadyOut),
      .aluResultIn           (aluResultIn),
      .aluResultSpecialIn    (aluResultSpecialIn),
      .destRegIn             (destRegIn),
      .destRegValidIn        (destRegValidIn),
      .destRegSpecialIn      (destRegSpecialIn),
      .destRegSpecialValidIn (destRegSpecialValidIn),
      .currentRipIn          (currentRipIn),
      .killIn                (killIn),
      .rfWriteEnOut          (rfWriteEnOut),
      .rfWriteRegOut         (rfWriteRegOut),
      .rfWriteDataOut        (rfWriteDataOut),
      .sbClearValidOut       (sbClearValidOut),
      .sbClearRegOut         (sbClearRegOut),
      .retireValidOut        (retireValidOut),
      .retireRipOut          (retireRipOut),
      .retireCountOut        (retireCountOut),
      .haltedOut             (haltedOut)
   );

   // One expected output cycle of the writeback port
   typedef struct {
      logic        we;
      logic [3:0]  rg;
      logic [63:0] data;
      logic        retire;
      logic [63:0] rip;
      logic        kill;
   } expEnt_t;

   expEnt_t          expQ[$];
   expEnt_t          cur;
   logic             mHalted;
   logic             mReady;
   logic [CNT_W-1:0] mCount;
   int               passCnt = 0;
   int               checkCnt = 0;
   int               failCnt = 0;

   function automatic expEnt_t mkEnt(input logic we, input logic [3:0] rg, input logic [63:0] data,
                                     input logic retire, input logic [63:0] rip, input logic kill);
      expEnt_t e;
      e.we = we; e.rg = rg; e.data = data; e.retire = retire; e.rip = rip; e.kill = kill;
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCnt++;
      assert (obs === exp) passCnt++;
      else begin
         failCnt++;
         $error("FAIL %s at %0t: observed 0x%0h expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic modelReset();
      expQ.delete();
      cur     = mkEnt(1'b0, 4'd0, 64'd0, 1'b0, 64'd0, 1'b0);
      mHalted = 1'b0;
      mReady  = 1'b1;
      mCount  = '0;
   endtask

   task automatic checkAll();
      check("rfWriteEn", 64'(rfWriteEnOut), 64'(cur.we));
      check("sbClearValid", 64'(sbClearValidOut), 64'(cur.we));
      if (cur.we) begin
         check("rfWriteReg", 64'(rfWriteRegOut), 64'(cur.rg));
         check("rfWriteData", rfWriteDataOut, cur.data);
         check("sbClearReg", 64'(sbClearRegOut), 64'(cur.rg));
      end
      check("retireValid", 64'(retireValidOut), 64'(cur.retire));
      if (cur.retire) begin
         check("retireRip", retireRipOut, cur.rip);
      end
      check("retireCount", 64'(retireCountOut), 64'(mCount));
      check("halted", 64'(haltedOut), 64'(mHalted));
      check("wbReady", 64'(wbReadyOut), 64'(mReady));
   endtask

   // Turn the instruction currently on the inputs into its expected output cycles
   task automatic pushInstr();
      if (killIn) begin
         expQ.push_back(mkEnt(1'b0, destRegIn, aluResultIn, 1'b1, currentRipIn, 1'b1));
      end else if (destRegSpecialValidIn) begin
         expQ.push_back(mkEnt(destRegValidIn, destRegIn, aluResultIn, 1'b0, currentRipIn, 1'b0));
         expQ.push_back(mkEnt(1'b1, destRegSpecialIn, aluResultSpecialIn, 1'b1, currentRipIn, 1'b0));
      end else begin
         expQ.push_back(mkEnt(destRegValidIn, destRegIn, aluResultIn, 1'b1, currentRipIn, 1'b0));
      end
   endtask

   task automatic tick();
      logic acc;
      acc = exValidIn && mReady;
      @(posedge clk);
      if (cur.kill) mHalted = 1'b1;
      if (acc) pushInstr();
      if (expQ.size() > 0) cur = expQ.pop_front();
      else cur = mkEnt(1'b0, 4'd0, 64'd0, 1'b0, 64'd0, 1'b0);
      if (cur.retire) mCount = mCount + CNT_W'(1);
      mReady = !mHalted && !cur.kill && (expQ.size() == 0);
      @(negedge clk);
      checkAll();
   endtask

   task automatic send(input logic v, input logic k, input logic dv, input logic sv,
                       input logic [3:0] dr, input logic [3:0] sr, input logic [63:0] d,
                       input logic [63:0] sd, input logic [63:0] rip);
      exValidIn = v; killIn = k; destRegValidIn = dv; destRegSpecialValidIn = sv;
      destRegIn = dr; destRegSpecialIn = sr; aluResultIn = d; aluResultSpecialIn = sd;
      currentRipIn = rip;
   endtask

   task automatic sendIdle();
      send(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 64'd0, 64'd0, 64'd0);
   endtask

   task automatic sendRandom();
      send(($urandom_range(0, 3) != 0), 1'b0, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom});
   endtask

   initial begin
      reset_n = 1'b0;
      sendIdle();
      modelReset();
      repeat (2) @(negedge clk);
      checkAll();
      reset_n = 1'b1;

      // ADD r3 <- 0x10
      send(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 64'h10, 64'd0, 64'h1000);
      tick();
      check("addCount", 64'(retireCountOut), 64'd1);
      sendIdle();
      tick();

      // MUL: RAX low, RDX high over two cycles
      send(1'b1, 1'b0, 1'b1, 1'b1, REG_RAX, REG_RDX, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1004);
      tick();
      sendIdle();
      tick();
      tick();

      // Four back-to-back single-destination ops
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 1'b0, 1'b1, 1'b0, 4'(i + 5), 4'd0, 64'(i * 3 + 7), 64'd0, 64'(32'h2000 + i * 4));
         tick();
      end
      check("b2bCount", 64'(retireCountOut), 64'd6);
      sendIdle();
      tick();

      // Same destination for both halves: special value written last
      send(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 4'd7, 64'hAAAA, 64'hBBBB, 64'h3000);
      tick();
      sendIdle();
      tick();
      tick();

      for (int i = 0; i < 300; i++) begin
         sendRandom();
         tick();
      end
      sendIdle();
      repeat (3) tick();

      // CMP (no write) then RET (kill) then ignored traffic
      send(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 64'h55, 64'd0, 64'h4000);
      tick();
      send(1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 4'd2, 64'h66, 64'h77, 64'h4004);
      tick();
      send(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 4'd0, 64'h88, 64'd0, 64'h4008);
      repeat (4) tick();

      sendIdle();
      reset_n = 1'b0;
      #1;
      modelReset();
      checkAll();
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Reset while the RDX half is on the write port
      send(1'b1, 1'b0, 1'b1, 1'b1, REG_RAX, REG_RDX, 64'h123, 64'h456, 64'h5000);
      tick();
      sendIdle();
      @(posedge clk);
      #2;
      check("rdxStrobe", 64'(rfWriteEnOut), 64'd1);
      reset_n = 1'b0;
      #1;
      modelReset();
      checkAll();
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Counter wrap: 17 retires with a 4-bit counter
      for (int i = 0; i < 17; i++) begin
         send(1'b1, 1'b0, 1'b1, 1'b0, 4'(i), 4'd0, 64'(i + 100), 64'd0, 64'(32'h6000 + i * 4));
         tick();
      end
      sendIdle();
      tick();
      check("wrapCount", 64'(retireCountOut), 64'd1);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
